rsa_modexp_engine: RTL and testbench

- Parametrised successor to the fixed 8-bit RSA core: a self-contained modular exponentiation engine computing result = y^k mod n, with k selected by mode from the encrypt key e or decrypt key d.
- Internally it uses a bit-serial interleaved shift-add modular multiplier and left-to-right square-and-multiply.
- Instantiated under the RSA top-level with a start/ready/done handshake.
- Replaces the separate emul/modn pair and adds a runtime modulus, mode select, input pre-reduction and error reporting.

---
 rtl/rsa_modexp_engine.sv | 161 ++++++++++++++++
 tb/tb_rsa_modexp_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_engine.sv
// Modular exponentiation engine: result = y^k mod n, k = mode ? d : e.
// Left-to-right square-and-multiply driven by a bit-serial interleaved shift-add multiplier.
module rsa_modexp_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] e,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic [DATA_WIDTH-1:0] n,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ready,
    output logic                  done,
    output logic                  err
);
    localparam int W  = DATA_WIDTH;
    localparam int AW = DATA_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] TOP   = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [W-1:0]         ONE_W = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REDUCE, S_SQR, S_MUL, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W-1:0]         r_y, r_n, r_k, r_ybar, r_r, r_result;
    logic [AW-1:0]        r_acc;
    logic [CNT_WIDTH-1:0] r_cnt, r_idx;
    logic                 r_bad, r_done, r_err;

    logic                 w_ready, w_mm_active, w_mm_last;
    logic                 w_b_bit, w_k_bit, w_idx_zero, w_n_small;
    logic [W-1:0]         w_a, w_b;
    logic [AW-1:0]        w_n_ext, w_dbl, w_dbl_red, w_add, w_mm;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   w_next = w_n_small ? S_DONE : S_REDUCE;
            S_REDUCE: if (w_mm_last) w_next = S_SQR;
            S_SQR: begin
                if (w_mm_last) begin
                    if (w_k_bit)         w_next = S_MUL;
                    else if (w_idx_zero) w_next = S_DONE;
                    else                 w_next = S_SQR;
                end
            end
            S_MUL:    if (w_mm_last) w_next = w_idx_zero ? S_DONE : S_SQR;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output / control decode, including multiplier operand selection
    always_comb begin
        w_ready     = (r_state == S_IDLE);
        w_mm_active = (r_state == S_REDUCE) || (r_state == S_SQR) || (r_state == S_MUL);
        w_mm_last   = w_mm_active && (r_cnt == '0);
        w_idx_zero  = (r_idx == '0);
        w_n_small   = (r_n[W-1:1] == '0);
        w_a         = r_r;
        w_b         = r_r;
        case (r_state)
            S_REDUCE: begin
                w_a = ONE_W;
                w_b = r_y;
            end
            S_MUL:    w_b = r_ybar;
            default: begin
                w_a = r_r;
                w_b = r_r;
            end
        endcase
        w_b_bit = |(w_b & (ONE_W << r_cnt));
        w_k_bit = |(r_k & (ONE_W << r_idx));
    end

    // One interleaved shift-add step; acc stays < n so W+2 bits never overflow
    always_comb begin
        w_n_ext   = {2'b00, r_n};
        w_dbl     = r_acc << 1;
        w_dbl_red = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
        w_add     = w_dbl_red + (w_b_bit ? {2'b00, w_a} : '0);
        w_mm      = (w_add >= w_n_ext) ? (w_add - w_n_ext) : w_add;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_y      <= '0;
            r_n      <= '0;
            r_k      <= '0;
            r_ybar   <= '0;
            r_r      <= '0;
            r_result <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_bad    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_y      <= y;
                    r_n      <= n;
                    r_k      <= mode ? d : e;
                    r_err    <= 1'b0;
                    r_result <= '0;
                    r_bad    <= 1'b0;
                end
            end else if (r_state == S_LOAD) begin
                r_bad <= w_n_small;
                r_r   <= w_n_small ? '0 : ONE_W;
                r_idx <= TOP;
                r_cnt <= TOP;
                r_acc <= '0;
            end else if (w_mm_active) begin
                if (w_mm_last) begin
                    r_acc <= '0;
                    r_cnt <= TOP;
                    if (r_state == S_REDUCE) begin
                        r_ybar <= w_mm[W-1:0];
                    end else begin
                        r_r <= w_mm[W-1:0];
                        // idx moves on after SQR only when no MUL follows for this bit
                        if (!w_idx_zero && ((r_state == S_MUL) || !w_k_bit))
                            r_idx <= r_idx - CNT_WIDTH'(1);
                    end
                end else begin
                    r_acc <= w_mm;
                    r_cnt <= r_cnt - CNT_WIDTH'(1);
                end
            end else if (r_state == S_DONE) begin
                r_result <= r_r;
                r_done   <= 1'b1;
                r_err    <= r_bad;
            end
        end
    end

    assign result = r_result;
    assign ready  = w_ready;
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine (W=8): scoreboard of result/err/latency,
// compared by a negedge monitor whenever done pulses.
module tb_rsa_modexp_engine;
  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic         start;
  logic         mode;
  logic [W-1:0] e, d, y, n;
  logic [W-1:0] result;
  logic         ready, done, err;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  int           exp_lat_q[$];

  rsa_modexp_engine #(.DATA_WIDTH(W), .CNT_WIDTH(5)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .e     (e),
    .d     (d),
    .y     (y),
    .n     (n),
    .result(result),
    .ready (ready),
    .done  (done),
    .err   (err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // monitor: counts edges since accept, compares on done
  int cyc = 0;
  bit active = 0;
  bit accept_next = 0;
  bit ready_seen = 0;

  always @(negedge clock) begin
    if (!reset) begin
      active = 0;
      accept_next = 0;
    end else begin
      if (accept_next) begin
        active = 1;
        cyc = 0;
        ready_seen = 0;
        accept_next = 0;
      end else if (active) begin
        cyc++;
      end
      if (active && !done && ready) ready_seen = 1;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("result", int'(result), int'(exp_q.pop_front()));
          chk("err", int'(err), int'(exp_err_q.pop_front()));
          chk("latency", active ? cyc : -1, exp_lat_q.pop_front());
          chk("ready_low_during_run", int'(ready_seen), 0);
          chk("ready_at_done", int'(ready), 1);
        end
        active = 0;
      end
      accept_next = ready && start;
    end
  end

  // driver tasks
  task automatic set_inputs(input logic m, input logic [W-1:0] ee, input logic [W-1:0] dd,
                            input logic [W-1:0] yy, input logic [W-1:0] nn);
    mode = m;
    e = ee;
    d = dd;
    y = yy;
    n = nn;
  endtask

  task automatic push_exp(input logic [W-1:0] res, input logic er, input int lat);
    exp_q.push_back(res);
    exp_err_q.push_back(er);
    exp_lat_q.push_back(lat);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(posedge clock); #1;
      i++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic m, input logic [W-1:0] ee, input logic [W-1:0] dd,
                     input logic [W-1:0] yy, input logic [W-1:0] nn,
                     input logic [W-1:0] res, input logic er, input int lat);
    set_inputs(m, ee, dd, yy, nn);
    push_exp(res, er, lat);
    pulse_start();
    wait_done(400);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    set_inputs(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    #12;
    chk("reset_result", int'(result), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_ready", int'(ready), 1);
    @(posedge clock); #1 reset = 1'b1;

    // main function vectors: m, e, d, y, n, result, err, latency
    run(1'b0, 8'd7,   8'd103, 8'd42,  8'd143, 8'd81,  1'b0, 98);
    run(1'b1, 8'd7,   8'd103, 8'd81,  8'd143, 8'd42,  1'b0, 114);
    run(1'b0, 8'd1,   8'd0,   8'd200, 8'd143, 8'd57,  1'b0, 82);
    run(1'b0, 8'd0,   8'd9,   8'd99,  8'd143, 8'd1,   1'b0, 74);
    run(1'b0, 8'd5,   8'd0,   8'd0,   8'd143, 8'd0,   1'b0, 90);
    run(1'b0, 8'd7,   8'd3,   8'd9,   8'd1,   8'd0,   1'b1, 2);
    run(1'b1, 8'd3,   8'd5,   8'd200, 8'd0,   8'd0,   1'b1, 2);
    run(1'b0, 8'd7,   8'd103, 8'd42,  8'd143, 8'd81,  1'b0, 98);
    run(1'b0, 8'd5,   8'd0,   8'd3,   8'd251, 8'd243, 1'b0, 90);
    run(1'b0, 8'd255, 8'd0,   8'd254, 8'd255, 8'd254, 1'b0, 138);
    run(1'b0, 8'd3,   8'd0,   8'd7,   8'd2,   8'd1,   1'b0, 90);
    run(1'b1, 8'd99,  8'd2,   8'd13,  8'd200, 8'd169, 1'b0, 82);

    // start pulses and input changes mid-run are ignored
    set_inputs(1'b0, 8'd7, 8'd103, 8'd42, 8'd143);
    push_exp(8'd81, 1'b0, 98);
    pulse_start();
    repeat (40) @(posedge clock);
    #1 set_inputs(1'b1, 8'd3, 8'd5, 8'd5, 8'd77);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (18) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done(400);

    // start held across DONE: second run accepted on the first IDLE cycle
    set_inputs(1'b0, 8'd7, 8'd103, 8'd42, 8'd143);
    push_exp(8'd81, 1'b0, 98);
    push_exp(8'd42, 1'b0, 114);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 set_inputs(1'b1, 8'd7, 8'd103, 8'd81, 8'd143);
    wait_done(400);
    @(posedge clock); #1 start = 1'b0;
    wait_done(400);

    // asynchronous reset during MUL aborts without a done pulse
    set_inputs(1'b0, 8'd7, 8'd103, 8'd42, 8'd143);
    push_exp(8'd81, 1'b0, 98);
    pulse_start();
    repeat (60) @(posedge clock);
    #2 reset = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_err_q.pop_back());
    void'(exp_lat_q.pop_back());
    #1;
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_err", int'(err), 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    run(1'b1, 8'd7, 8'd103, 8'd81, 8'd143, 8'd42, 1'b0, 114);

    repeat (5) @(posedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
